// File: rtl/multi_tick_pkg.sv
// Shared constants for the multi-channel tick generator: default widths/divisors,
// LFSR seed/taps and the standard game rate divisors.
package multi_tick_pkg;

    localparam int          CNT_W_DEF  = 30;
    localparam int unsigned DIV_DEF    = 7500000;

    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    localparam int unsigned MOVE_DIV   = 7500000;
    localparam int unsigned BLUE_DIV   = 2500000;
    localparam int unsigned GREEN_DIV  = 2000000;
    localparam int unsigned YELLOW_DIV = 3000000;
    localparam int unsigned SEC_DIV    = 55000000;

    // Galois step, x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One divider channel: counter, active/shadow divisor, tick strobe and div_clk toggle.
// Shadow divisor is only promoted at terminal count (or sync) so half-periods never truncate.
module tick_channel
    import multi_tick_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DIV_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] div_data,
    output logic             tick,
    output logic             div_clk,
    output logic             wr_pend
);

    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] shadow;
    logic             term;

    assign term = (cnt == div_act);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt     <= '0;
            tick    <= 1'b0;
            div_clk <= 1'b0;
            wr_pend <= 1'b0;
            div_act <= DIV_INIT;
            shadow  <= DIV_INIT;
        end else if (sync) begin
            cnt     <= '0;
            tick    <= 1'b0;
            div_clk <= 1'b0;
            wr_pend <= 1'b0;
            if (wr) begin
                div_act <= div_data;
                shadow  <= div_data;
            end else if (wr_pend) begin
                div_act <= shadow;
            end
        end else begin
            if (en) begin
                if (term) begin
                    cnt     <= '0;
                    tick    <= 1'b1;
                    div_clk <= ~div_clk;
                    if (wr_pend) begin
                        div_act <= shadow;
                        wr_pend <= 1'b0;
                    end
                end else begin
                    cnt  <= cnt + 1'b1;
                    tick <= 1'b0;
                end
            end else begin
                tick <= 1'b0;
            end
            // A write landing on the terminal cycle stays pending for the next one
            if (wr) begin
                shadow  <= div_data;
                wr_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_tick_gen.sv
// Multi-channel clock-enable generator: address decode, sync fan-out, N_CH tick_channels.
// Define MULTI_TICK_LFSR_EN to add the 16-bit rnd output advanced by tick[0].
module multi_tick_gen
    import multi_tick_pkg::*;
#(
    parameter  int          N_CH        = 4,
    parameter  int          CNT_W       = CNT_W_DEF,
    parameter  int unsigned DEFAULT_DIV = DIV_DEF,
    localparam int          SEL_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             sync,
    input  logic             div_wr,
    input  logic [SEL_W-1:0] ch_sel,
    input  logic [CNT_W-1:0] div_data,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  div_clk,
    output logic [N_CH-1:0]  wr_pend
`ifdef MULTI_TICK_LFSR_EN
    ,
    output logic [15:0]      rnd
`endif
);

    // Out-of-range ch_sel matches no channel, so the write is dropped
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        tick_channel #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .CLK     (CLK),
            .RST     (RST),
            .en      (en),
            .sync    (sync),
            .wr      (div_wr && (ch_sel == SEL_W'(i))),
            .div_data(div_data),
            .tick    (tick[i]),
            .div_clk (div_clk[i]),
            .wr_pend (wr_pend[i])
        );
    end

`ifdef MULTI_TICK_LFSR_EN
    always_ff @(posedge CLK) begin
        if (RST || sync) begin
            rnd <= LFSR_SEED;
        end else if (tick[0]) begin
            rnd <= lfsr_next(rnd);
        end
    end
`endif

endmodule
